stopwatch_core: RTL

Timekeeping core of the stopwatch: produces the `min`/`sec` values that the 7-segment display driver renders, plus the `sel`/`adj` mode signals that drive its blink logic. It conditions the raw pause and reset buttons (synchronise, debounce, edge-detect) and runs a run/pause state machine. It counts MM:SS at 1 Hz in normal mode, or steps the selected field at 2 Hz in adjust mode. It sits between the clock-divider enables and the display driver, entirely in one clock domain.

---
 rtl/stopwatch_core.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: button conditioning, run/pause control and
// MM:SS counting (1 Hz normal, 2 Hz single-field adjust).
//
// state | meaning
// ------+------------------------------------------
// PAUSE | counting halted, one_hz_en ignored
// RUN   | seconds advance on each one_hz_en
module stopwatch_core #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       one_hz_en,
    input  logic       two_hz_en,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_sel,
    input  logic       sw_adj,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sel,
    output logic       adj,
    output logic       running
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ST_PAUSE = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // index 0 = pause button, index 1 = reset button
    logic [1:0]    btn_raw;
    logic [1:0]    b_s1;
    logic [1:0]    b_s2;
    logic [1:0]    b_lvl;
    logic [1:0]    b_lvl_q;
    logic [1:0]    b_arm;
    logic [1:0]    vld;
    logic [CW-1:0] b_cnt [2];
    logic [1:0]    pulse;
    logic          pause_p;
    logic          reset_p;

    logic          sel_s1;
    logic          adj_s1;
    logic [0:0]    state;

    assign btn_raw = {btn_reset, btn_pause};

    // A press is only reported once the button has been seen released after
    // reset, so a button held through reset cannot fire on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_s1    <= '0;
            b_s2    <= '0;
            b_lvl   <= '0;
            b_lvl_q <= '0;
            b_arm   <= '0;
            vld     <= '0;
            for (int i = 0; i < 2; i++) begin
                b_cnt[i] <= '0;
            end
        end else begin
            b_s1    <= btn_raw;
            b_s2    <= b_s1;
            b_lvl_q <= b_lvl;
            vld     <= {vld[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                if (b_s2[i] == b_lvl[i]) begin
                    b_cnt[i] <= '0;
                end else if (b_cnt[i] == CNT_LAST) begin
                    b_lvl[i] <= b_s2[i];
                    b_cnt[i] <= '0;
                end else begin
                    b_cnt[i] <= b_cnt[i] + CW'(1);
                end
                if (vld[1] && !b_s2[i]) begin
                    b_arm[i] <= 1'b1;
                end
            end
        end
    end

    assign pulse   = b_lvl & ~b_lvl_q & b_arm;
    assign pause_p = pulse[0];
    assign reset_p = pulse[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1 <= 1'b0;
            adj_s1 <= 1'b0;
            sel    <= 1'b0;
            adj    <= 1'b0;
        end else begin
            sel_s1 <= sw_sel;
            adj_s1 <= sw_adj;
            sel    <= sel_s1;
            adj    <= adj_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PAUSE;
        end else if (pause_p) begin
            state <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    assign running = (state == ST_RUN);

    function automatic logic [5:0] inc59(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // running is the pre-toggle state, so a coincident pause_p does not
    // affect whether this cycle's tick counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min <= 6'd0;
            sec <= 6'd0;
        end else if (reset_p) begin
            min <= 6'd0;
            sec <= 6'd0;
        end else if (adj && two_hz_en) begin
            if (sel) begin
                sec <= inc59(sec);
            end else begin
                min <= inc59(min);
            end
        end else if (!adj && running && one_hz_en) begin
            if (sec >= 6'd59) begin
                sec <= 6'd0;
                min <= inc59(min);
            end else begin
                sec <= sec + 6'd1;
            end
        end
    end

endmodule
